// File: rtl/fft_pkg.sv
// Shared types and constants for the 32-point R2SDF FFT pipeline.
package fft_pkg;

  localparam int DATA_W  = 16;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;
  localparam int N_POINT = 32;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } cplx_t;

  // Clamp a wide signed intermediate to the sample range.
  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [33:0] v);
    if (v > 34'(SAT_MAX))      return DATA_W'(SAT_MAX);
    else if (v < 34'(SAT_MIN)) return DATA_W'(SAT_MIN);
    else                       return DATA_W'(v);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// W32^m twiddle lookup, m = 0..15: cos and -sin of 2*pi*m/32 in Q1.14.
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic        [3:0]      m,
  input  logic                   unused_tie,
  output logic signed [TW_W-1:0] cos_q,
  output logic signed [TW_W-1:0] msin_q
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cos_q  = 16'sd16384;
    msin_q = 16'sd0;
    case (m)
      4'd0:  begin cos_q =  16'sd16384; msin_q =  16'sd0;     end
      4'd1:  begin cos_q =  16'sd16069; msin_q = -16'sd3196;  end
      4'd2:  begin cos_q =  16'sd15137; msin_q = -16'sd6270;  end
      4'd3:  begin cos_q =  16'sd13623; msin_q = -16'sd9102;  end
      4'd4:  begin cos_q =  16'sd11585; msin_q = -16'sd11585; end
      4'd5:  begin cos_q =  16'sd9102;  msin_q = -16'sd13623; end
      4'd6:  begin cos_q =  16'sd6270;  msin_q = -16'sd15137; end
      4'd7:  begin cos_q =  16'sd3196;  msin_q = -16'sd16069; end
      4'd8:  begin cos_q =  16'sd0;     msin_q = -16'sd16384; end
      4'd9:  begin cos_q = -16'sd3196;  msin_q = -16'sd16069; end
      4'd10: begin cos_q = -16'sd6270;  msin_q = -16'sd15137; end
      4'd11: begin cos_q = -16'sd9102;  msin_q = -16'sd13623; end
      4'd12: begin cos_q = -16'sd11585; msin_q = -16'sd11585; end
      4'd13: begin cos_q = -16'sd13623; msin_q = -16'sd9102;  end
      4'd14: begin cos_q = -16'sd15137; msin_q = -16'sd6270;  end
      4'd15: begin cos_q = -16'sd16069; msin_q = -16'sd3196;  end
      default: ;
    endcase
  end

  logic unused;
  assign unused = unused_tie;

endmodule

// File: rtl/fft_r2sdf_stage.sv
// One radix-2 SDF DIF butterfly stage (feedback FIFO, butterfly, twiddle multiply).
// Optional macro FFT_STAGE_SCALE_EN halves sum/difference instead of saturating.
module fft_r2sdf_stage
  import fft_pkg::*;
#(
  parameter int DELAY   = 16,
  parameter int N_POINT = fft_pkg::N_POINT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i,
  output logic                     out_first
);

  localparam int CNT_W = $clog2(2 * DELAY);
  localparam int STEP  = (N_POINT / 2) / DELAY;

  logic [CNT_W-1:0] cnt;
  logic             primed;
  logic             phase_b;
  cplx_t            fifo [DELAY];
  cplx_t            head, push;

  assign head    = fifo[DELAY-1];
  assign phase_b = (cnt >= CNT_W'(DELAY));

  function automatic logic signed [DATA_W-1:0] bfly_reduce(input logic signed [DATA_W:0] v);
`ifdef FFT_STAGE_SCALE_EN
    return v[DATA_W:1];
`else
    return sat_data(34'(v));
`endif
  endfunction

  // Butterfly: a = FIFO head (first half), b = current input (second half).
  logic signed [DATA_W:0] sum_r, sum_i, dif_r, dif_i;
  assign sum_r = 17'(head.r) + 17'(in_r);
  assign sum_i = 17'(head.i) + 17'(in_i);
  assign dif_r = 17'(head.r) - 17'(in_r);
  assign dif_i = 17'(head.i) - 17'(in_i);

  assign push = phase_b ? cplx_t'{r: bfly_reduce(dif_r), i: bfly_reduce(dif_i)}
                        : cplx_t'{r: in_r, i: in_i};

  // NOTE: the delay line carries no reset; stale contents are masked by primed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      fifo[0] <= push;
      for (int k = 1; k < DELAY; k++) fifo[k] <= fifo[k-1];
    end
  end

  // Twiddle index k*16/DELAY; only meaningful in phase A where cnt < DELAY.
  logic [3:0] tw_m;
  int         tw_idx;
  always_comb begin
    tw_idx = int'(cnt) * STEP;
    tw_m   = tw_idx[3:0];
  end

  logic signed [TW_W-1:0] tw_c, tw_s;
  fft_twiddle_rom u_rom (
    .m          (tw_m),
    .unused_tie (1'b0),
    .cos_q      (tw_c),
    .msin_q     (tw_s)
  );

  logic signed [31:0] p_ac, p_bd, p_ad, p_bc;
  logic signed [32:0] acc_r, acc_i, shr_r, shr_i;
  assign p_ac  = 32'(head.r) * 32'(tw_c);
  assign p_bd  = 32'(head.i) * 32'(tw_s);
  assign p_ad  = 32'(head.r) * 32'(tw_s);
  assign p_bc  = 32'(head.i) * 32'(tw_c);
  assign acc_r = 33'(p_ac) - 33'(p_bd) + 33'sd8192;
  assign acc_i = 33'(p_ad) + 33'(p_bc) + 33'sd8192;
  assign shr_r = acc_r >>> TW_FRAC;
  assign shr_i = acc_i >>> TW_FRAC;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (phase_b) begin
          out_r     <= bfly_reduce(sum_r);
          out_i     <= bfly_reduce(sum_i);
          out_valid <= 1'b1;
          out_first <= (cnt == CNT_W'(DELAY));
          primed    <= 1'b1;
        end else begin
          out_r     <= sat_data(34'(shr_r));
          out_i     <= sat_data(34'(shr_i));
          out_valid <= primed;
        end
      end
    end
  end

endmodule

// File: doc/fft_r2sdf_stage.md
Name: fft_r2sdf_stage

Overview:
- One radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency butterfly stage of the 32-point FFT pipeline.
- Five instances chained with DELAY = 16, 8, 4, 2, 1 form the transform core.
- The DELAY=1 instance drives the bit-reversal sorting stage directly; its out_first pulse is the sorter's start_sorting.
- Streams one complex sample per accepted cycle, with a delay-line FIFO, butterfly, twiddle multiply and saturation.

Parameters:
- DELAY, 16, feedback FIFO depth and half-span of the butterfly; legal values 16/8/4/2/1.
- N_POINT, 32, transform size; fixes the twiddle step as 16/DELAY.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input sample valid; the stage advances only when high.
- in_r  input  16  signed real part of the input sample.
- in_i  input  16  signed imaginary part of the input sample.
- out_valid  output  1  output sample valid.
- out_r  output  16  signed real part of the result, registered.
- out_i  output  16  signed imaginary part of the result, registered.
- out_first  output  1  one-cycle pulse marking the first output sample of a frame.

Behaviour:
- Reset: asynchronous, active-high, the single clock is clk.
  - out_valid=0, out_first=0, out_r=out_i=0, cnt=0, primed=0.
  - FIFO contents are don't-care; they are masked by primed.
- Counter: cnt is mod 2*DELAY and increments only on accepted samples (in_valid=1).
  - Phase A: cnt < DELAY.
  - Phase B: cnt >= DELAY.
- Phase A:
  - The input sample is pushed into the FIFO.
  - The popped FIFO head is the difference term d from the previous frame. It is multiplied by W32^(k*16/DELAY), with k = cnt, and registered to the output.
  - out_valid = primed.
- Phase B:
  - a = FIFO head, b = input.
  - a+b is registered to the output; a-b is pushed into the FIFO.
  - out_valid=1 and primed is set.
  - out_first=1 when cnt==DELAY.
- Latency: a sum output appears 1 cycle after the accepting edge of its b sample. Its matching difference appears DELAY accepted samples later.
- Stall: with in_valid=0 there is no FIFO shift, no cnt change, out_valid=0 and out_first=0. out_r/out_i hold their value.
- Flush: upstream appends one zero-valued frame to drain the last frame's difference terms. No self-drain.
- Arithmetic:
  - Sum and difference are formed at 17 bits, then reduced to 16 bits by saturation to [-32768, 32767].
  - Twiddles are Q1.14 in 16 bits: cos and -sin of 2*pi*m/32 for m = 0..15. W^0 = (16384, 0).
  - Complex multiply uses 4 signed 16x16 products.
  - Real part = ac - bd, imaginary part = ad + bc, each at 33 bits.
  - Each part gets +8192 added, is arithmetically shifted right by 14, then saturated to 16 bits.
  - With DELAY=1, k is always 0, so the multiply path is an identity.
- Reset mid-frame: the partial frame is discarded and the next accepted sample is treated as cnt=0.
- Simultaneous events: rst dominates in_valid.

Optional Feature:
- Macro: FFT_STAGE_SCALE_EN.
- Defined: sum and difference are divided by 2 via arithmetic shift right by 1 of the 17-bit value (truncating). Saturation can then never trigger, and the 5-stage pipeline output is scaled by 1/32.
- Undefined: full-scale sum and difference with 16-bit saturation as above.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_W=16, TW_W=16, TW_FRAC=14, N_POINT=32.
  - The complex sample typedef (r, i).
  - The saturation constants SAT_MAX=32767 and SAT_MIN=-32768.
- Sub-module fft_twiddle_rom:
  - Combinational 16-entry lookup.
  - Input: 4-bit index m. Outputs: cos and -sin in Q1.14.
  - Instantiated once per stage and shared by every stage.

Test Plan:
- DELAY=1, scale off:
  - Stimulus: accept (100,0) then (20,0) on consecutive cycles.
  - Response: next cycle out=(120,0) with out_first=1.
  - Then accept (0,0),(0,0): out=(80,0) one cycle after the first zero, with out_first=0.
- DELAY=8, twiddle:
  - Stimulus: frame with x[4]=(1000,0) and all other samples 0, followed by a zero frame.
  - Response: sum outputs: 5th = (1000,0), others 0.
  - Difference outputs: 5th = (0,-1000), since W32^8 = -j; others 0.
- DELAY=1, saturation, scale off:
  - Stimulus: (30000,0) then (-30000,0).
  - Response: sum=(0,0).
  - Stimulus: (30000,0) then (30000,0).
  - Response: sum=(32767,0).
  - Stimulus: (30000,0) then (-30000,0).
  - Response: diff=(32767,0).
- Scale on:
  - Same stimulus as the saturation case.
  - Response: sum=(0,0), diff=(30000,0), with no saturation.
- Stall, DELAY=2:
  - Stimulus: deassert in_valid for 3 cycles mid-frame.
  - Response: out_valid=0 during the gap; output sequence identical to gap-free run.
- Reset mid-frame:
  - Stimulus: assert rst after 5 samples.
  - Response: all outputs 0 immediately.
  - A following clean frame gives the same results as a run from power-up, and out_valid stays low through the first phase A.
